redirect_ctrl: RTL
==================

# redirect_ctrl

Redirect controller that sequences the program-counter redirect path between the instruction committer, the interrupt source and the fence/flush source, and the Program Counter Generator. It accepts one redirect at a time by fixed priority and drives the selected target to the PCG as an AXI-Stream beat. It asserts a pipeline flush for a programmable drain window and holds the committer until the redirect has fully taken effect. It also keeps a free-running redirect counter for performance monitoring.

## Interface
- `XLEN`, 32: PC/target width (matches `riscv_pkg`).
- `FLUSH_CYCLES`, 2: drain cycles after the PCG handshake; legal range 1..15.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (one clock domain only).
- `cmt_vld`  in  1  committer redirect request (taken branch / `use_new_pc`).
- `cmt_pc`  in  XLEN  committer redirect target.
- `cmt_rdy`  out  1  request accepted this cycle.
- `irq_vld`  in  1  interrupt pending and enabled.
- `irq_pc`  in  XLEN  trap vector target (from CSR).
- `irq_ack`  out  1  interrupt accepted this cycle.
- `fnc_vld`  in  1  fence.i / flush-to-next-PC request.
- `fnc_pc`  in  XLEN  flush restart PC.
- `fnc_rdy`  out  1  request accepted this cycle.
- `pcg_tvalid`  out  1  redirect beat to PCG.
- `pcg_tdata`  out  XLEN  redirect target to PCG.
- `pcg_tready`  in  1  PCG accepts beat.
- `flush`  out  1  flush frontend, fetch FIFO and dispatcher.
- `commit_hold`  out  1  committer must not accept new instructions.
- `redirect_cnt`  out  32  number of completed PCG handshakes.

## Operation
- FSM states: IDLE, SEND, DRAIN.
- IDLE: if any request is valid, accept exactly one. Priority is cmt > irq > fnc: the older committed instruction's redirect precedes the interrupt. Assert the winner's `*_rdy`/`irq_ack` combinationally in that cycle only. Latch its PC into `tgt_q`. Go to SEND.
- Losers are not acknowledged and must hold their request. They are re-arbitrated on the next IDLE cycle.
- All `*_rdy`/`irq_ack` are 0 outside IDLE and while `rst` is low.
- SEND: `pcg_tvalid`=1, `pcg_tdata`=`tgt_q`, held stable until `pcg_tready`. On handshake: increment `redirect_cnt` (wraps 0xFFFFFFFF→0), load `drain_q`=FLUSH_CYCLES-1, go to DRAIN.
- DRAIN: if `drain_q`==0 go to IDLE, else decrement.
- `flush`=1 in SEND and DRAIN; 0 in IDLE.
- `commit_hold`=1 whenever state≠IDLE.
- `pcg_tdata` is `tgt_q` at all times. `tgt_q` is unchanged in SEND/DRAIN.
- Reset (asynchronous, any state): state IDLE, `tgt_q`=0, `drain_q`=0, `redirect_cnt`=0. All outputs become 0 immediately.
- A reset in mid-SEND drops the beat. The requester is not re-acknowledged.

## Timing
- Request valid in IDLE at cycle N → acknowledge at N (combinational). `pcg_tvalid` rises at N+1 (registered).
- `flush` and `commit_hold` are high from N+1 through the last DRAIN cycle.
- With `pcg_tready` held at 1: SEND lasts 1 cycle and DRAIN lasts FLUSH_CYCLES cycles. IDLE resumes at N+2+FLUSH_CYCLES, which is the earliest next acknowledge.
- Back-to-back requests are therefore separated by 2+FLUSH_CYCLES cycles.
- PCG backpressure extends SEND one cycle per cycle of `pcg_tready`=0. DRAIN timing is unchanged.
- `redirect_cnt` updates the cycle after the handshake.
- Request inputs are sampled only in IDLE. Changes in SEND/DRAIN have no effect.

## Test plan
- Single cmt request, `cmt_pc`=0x8000_0100, `pcg_tready`=1, FLUSH_CYCLES=2:
  - `cmt_rdy` pulses at N.
  - `pcg_tvalid`/`pcg_tdata`=0x8000_0100 at N+1.
  - `flush`/`commit_hold` high N+1..N+3; IDLE at N+4.
  - `redirect_cnt`=1.
- Simultaneous cmt (0x100), irq (0x200) and fnc (0x300):
  - Beats appear in the order 0x100, 0x200, 0x300, spaced 4 cycles apart.
  - Exactly one acknowledge per request.
- `pcg_tready`=0 for 5 cycles in SEND:
  - `pcg_tvalid`=1 and `pcg_tdata` stable throughout.
  - `flush` stays high; DRAIN starts after the handshake.
  - Total busy time is 1+5+2 cycles.
- irq asserted during DRAIN, held:
  - No `irq_ack` before IDLE.
  - Acknowledged on the first IDLE cycle.
- `rst` low asynchronously in mid-SEND:
  - `pcg_tvalid`, `flush`, `commit_hold` and `redirect_cnt` go to 0 immediately.
  - After release, a new cmt request is accepted normally.
- Preload-free wrap: issue 2^32 redirects (or force `redirect_cnt`=0xFFFF_FFFF) → `redirect_cnt` reads 0 after the next handshake.

Source files
------------

// File: rtl/redirect_ctrl_if.sv
// Redirect path bundle: committer/irq/fence requests in, PCG beat and pipeline controls out.
interface redirect_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            cmt_vld;
  logic [XLEN-1:0] cmt_pc;
  logic            cmt_rdy;
  logic            irq_vld;
  logic [XLEN-1:0] irq_pc;
  logic            irq_ack;
  logic            fnc_vld;
  logic [XLEN-1:0] fnc_pc;
  logic            fnc_rdy;
  logic            pcg_tvalid;
  logic [XLEN-1:0] pcg_tdata;
  logic            pcg_tready;
  logic            flush;
  logic            commit_hold;
  logic [31:0]     redirect_cnt;

  // Controller side
  modport master (
    input  cmt_vld, cmt_pc, irq_vld, irq_pc, fnc_vld, fnc_pc, pcg_tready,
    output cmt_rdy, irq_ack, fnc_rdy, pcg_tvalid, pcg_tdata, flush,
           commit_hold, redirect_cnt
  );

  // Requester / PCG side
  modport slave (
    output cmt_vld, cmt_pc, irq_vld, irq_pc, fnc_vld, fnc_pc, pcg_tready,
    input  cmt_rdy, irq_ack, fnc_rdy, pcg_tvalid, pcg_tdata, flush,
           commit_hold, redirect_cnt
  );
endinterface

// File: rtl/redirect_ctrl.sv
// Fixed-priority PC redirect sequencer: arbitrates cmt > irq > fnc, sends the
// target to the PCG, then flushes the pipeline for a programmable drain window.
module redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_tgt;
  logic [3:0]      r_drain;
  logic [31:0]     r_redirect_cnt;

  logic            w_cmt_rdy;
  logic            w_irq_ack;
  logic            w_fnc_rdy;
  logic            w_accept;
  logic [XLEN-1:0] w_sel_pc;
  logic            w_handshake;

  always_comb begin
    w_next      = r_state;
    w_cmt_rdy   = 1'b0;
    w_irq_ack   = 1'b0;
    w_fnc_rdy   = 1'b0;
    w_accept    = 1'b0;
    w_sel_pc    = '0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        // rst gating keeps acks low while reset is held, even with IDLE forced
        if (rst) begin
          if (bus.cmt_vld) begin
            w_cmt_rdy = 1'b1;
            w_sel_pc  = bus.cmt_pc;
          end else if (bus.irq_vld) begin
            w_irq_ack = 1'b1;
            w_sel_pc  = bus.irq_pc;
          end else if (bus.fnc_vld) begin
            w_fnc_rdy = 1'b1;
            w_sel_pc  = bus.fnc_pc;
          end
          w_accept = w_cmt_rdy | w_irq_ack | w_fnc_rdy;
          if (w_accept) w_next = SEND;
        end
      end
      SEND: begin
        if (bus.pcg_tready) begin
          w_handshake = 1'b1;
          w_next      = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_tgt          <= '0;
      r_drain        <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_tgt <= w_sel_pc;
      if (w_handshake) begin
        r_drain        <= DRAIN_LOAD;
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end else if (r_state == DRAIN && r_drain != '0) begin
        r_drain <= r_drain - 4'd1;
      end
    end
  end

  assign bus.cmt_rdy      = w_cmt_rdy;
  assign bus.irq_ack      = w_irq_ack;
  assign bus.fnc_rdy      = w_fnc_rdy;
  assign bus.pcg_tvalid   = (r_state == SEND);
  assign bus.pcg_tdata    = r_tgt;
  assign bus.flush        = (r_state != IDLE);
  assign bus.commit_hold  = (r_state != IDLE);
  assign bus.redirect_cnt = r_redirect_cnt;

endmodule
